// File: rtl/flex_pts_serializer_if.sv
// Load handshake and serial-side status bundle for flex_pts_serializer.
interface flex_pts_serializer_if #(
   parameter int NUM_BITS = 8
);
   logic                load_valid;
   logic                load_ready;
   logic [NUM_BITS-1:0] parallel_in;
   logic                abort;
   logic                serial_out;
   logic                busy;
   logic                done;

   modport master (
      output load_valid, parallel_in, abort,
      input  load_ready, serial_out, busy, done
   );

   modport slave (
      input  load_valid, parallel_in, abort,
      output load_ready, serial_out, busy, done
   );
endinterface

// File: rtl/flex_pts_serializer.sv
// Parallel-to-serial shifter with valid/ready load, programmable bit period,
// selectable shift order, zero-gap reload and synchronous abort.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | serial_out parked at IDLE_VAL, ready for a word
//   SHIFT | a word is on the wire; shreg head is the bit being driven
module flex_pts_serializer #(
   parameter int   NUM_BITS   = 8,
   parameter int   SHIFT_MSB  = 1,
   parameter int   BIT_PERIOD = 1,
   parameter logic IDLE_VAL   = 1'b1
) (
   input logic clk,
   input logic n_rst,
   flex_pts_serializer_if.slave bus
);

   localparam int BW = $clog2(NUM_BITS);
   localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam logic [BW-1:0] BIT_MAX = BW'(NUM_BITS - 1);
   localparam logic [PW-1:0] PER_MAX = PW'(BIT_PERIOD - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]       per_cnt_q, per_cnt_d;
   logic                serial_out_q, serial_out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                per_wrap;
   logic                last_cycle;
   logic                load_ready;
   logic                accept;
   logic [NUM_BITS-1:0] shreg_next;

   // The head is the bit currently on the wire; the shift drops it and
   // pulls the next one into the head position.
   function automatic logic head(input logic [NUM_BITS-1:0] v);
      return (SHIFT_MSB != 0) ? v[NUM_BITS-1] : v[0];
   endfunction

   // Handshake decode and next-state computation
   always_comb begin
      per_wrap   = (per_cnt_q == PER_MAX);
      last_cycle = (state_q == SHIFT) && per_wrap && (bit_cnt_q == BIT_MAX);
      load_ready = !bus.abort && ((state_q == IDLE) || last_cycle);
      accept     = bus.load_valid && load_ready;
      shreg_next = (SHIFT_MSB != 0) ? {shreg_q[NUM_BITS-2:0], IDLE_VAL}
                                    : {IDLE_VAL, shreg_q[NUM_BITS-1:1]};

      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      per_cnt_d    = per_cnt_q;
      serial_out_d = serial_out_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      if ((state_q == SHIFT) && bus.abort) begin
         state_d      = IDLE;
         shreg_d      = '1;
         bit_cnt_d    = '0;
         per_cnt_d    = '0;
         serial_out_d = IDLE_VAL;
         busy_d       = 1'b0;
      end else if (accept) begin
         // A reload in the last cycle still completes the previous word.
         state_d      = SHIFT;
         shreg_d      = bus.parallel_in;
         bit_cnt_d    = '0;
         per_cnt_d    = '0;
         serial_out_d = head(bus.parallel_in);
         busy_d       = 1'b1;
         done_d       = (state_q == SHIFT);
      end else if (state_q == SHIFT) begin
         if (per_wrap) begin
            per_cnt_d = '0;
            if (bit_cnt_q == BIT_MAX) begin
               state_d      = IDLE;
               shreg_d      = '1;
               bit_cnt_d    = '0;
               serial_out_d = IDLE_VAL;
               busy_d       = 1'b0;
               done_d       = 1'b1;
            end else begin
               bit_cnt_d    = bit_cnt_q + BW'(1);
               shreg_d      = shreg_next;
               serial_out_d = head(shreg_next);
            end
         end else begin
            per_cnt_d = per_cnt_q + PW'(1);
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         shreg_q      <= '1;
         bit_cnt_q    <= '0;
         per_cnt_q    <= '0;
         serial_out_q <= IDLE_VAL;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         per_cnt_q    <= per_cnt_d;
         serial_out_q <= serial_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.serial_out = serial_out_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_flex_pts_serializer.sv
// Directed bench: dut0 is MSB-first / period 1, dut1 is LSB-first / period 3.
module tb_flex_pts_serializer;

   logic clk;
   logic n_rst;
   int   checks;
   int   failures;

   flex_pts_serializer_if #(.NUM_BITS(8)) if0 ();
   flex_pts_serializer_if #(.NUM_BITS(8)) if1 ();

   flex_pts_serializer #(
      .NUM_BITS(8), .SHIFT_MSB(1), .BIT_PERIOD(1), .IDLE_VAL(1'b1)
   ) dut0 (
      .clk(clk), .n_rst(n_rst), .bus(if0.slave)
   );

   flex_pts_serializer #(
      .NUM_BITS(8), .SHIFT_MSB(0), .BIT_PERIOD(3), .IDLE_VAL(1'b1)
   ) dut1 (
      .clk(clk), .n_rst(n_rst), .bus(if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads a word on dut0 and checks the 8-bit serial sequence, done and busy.
   task automatic run_word0(input string tag, input logic [7:0] w, input logic [0:7] seq);
      @(negedge clk);
      if0.load_valid  = 1'b1;
      if0.parallel_in = w;
      for (int k = 0; k <= 9; k++) begin
         tick();
         if (k == 0) begin
            if0.load_valid  = 1'b0;
            if0.parallel_in = 8'h00;
         end
         if (k < 8) begin
            chk({tag, "_bit"}, 32'(if0.serial_out), 32'(seq[k]));
            chk({tag, "_busy"}, 32'(if0.busy), 32'd1);
            chk({tag, "_done_lo"}, 32'(if0.done), 32'd0);
         end else if (k == 8) begin
            chk({tag, "_done"}, 32'(if0.done), 32'd1);
            chk({tag, "_busy_end"}, 32'(if0.busy), 32'd0);
            chk({tag, "_idle_out"}, 32'(if0.serial_out), 32'd1);
         end else begin
            chk({tag, "_done_once"}, 32'(if0.done), 32'd0);
         end
      end
   endtask

   logic [0:7]  seq8;
   logic [0:15] seq16;

   initial begin
      checks   = 0;
      failures = 0;
      n_rst    = 1'b0;
      if0.load_valid = 1'b0; if0.parallel_in = 8'h00; if0.abort = 1'b0;
      if1.load_valid = 1'b0; if1.parallel_in = 8'h00; if1.abort = 1'b0;

      // Reset values
      #12;
      chk("rst_serial", 32'(if0.serial_out), 32'd1);
      chk("rst_busy",   32'(if0.busy),       32'd0);
      chk("rst_done",   32'(if0.done),       32'd0);
      chk("rst_ready",  32'(if0.load_ready), 32'd1);
      chk("rst_serial1", 32'(if1.serial_out), 32'd1);
      @(negedge clk);
      n_rst = 1'b1;

      // 0xA5 MSB first
      seq8 = 8'b1010_0101;
      run_word0("a5", 8'hA5, seq8);

      // Back-to-back 0xF0 then 0x0F with load_valid held
      seq16 = 16'b1111_0000_0000_1111;
      @(negedge clk);
      if0.load_valid  = 1'b1;
      if0.parallel_in = 8'hF0;
      for (int k = 0; k <= 17; k++) begin
         tick();
         if (k == 0) if0.parallel_in = 8'h0F;
         if (k == 8) if0.load_valid = 1'b0;
         if (k == 7) chk("b2b_ready_last", 32'(if0.load_ready), 32'd1);
         if (k == 3) chk("b2b_ready_mid", 32'(if0.load_ready), 32'd0);
         if (k < 16) begin
            chk("b2b_bit",  32'(if0.serial_out), 32'(seq16[k]));
            chk("b2b_busy", 32'(if0.busy), 32'd1);
            chk("b2b_done", 32'(if0.done), (k == 8) ? 32'd1 : 32'd0);
         end else if (k == 16) begin
            chk("b2b_done_end", 32'(if0.done), 32'd1);
            chk("b2b_busy_end", 32'(if0.busy), 32'd0);
            chk("b2b_idle_out", 32'(if0.serial_out), 32'd1);
         end else begin
            chk("b2b_done_once", 32'(if0.done), 32'd0);
         end
      end

      // Abort during bit 3 of 0x55 with load_valid high
      @(negedge clk);
      if0.load_valid  = 1'b1;
      if0.parallel_in = 8'h55;
      tick();
      if0.load_valid = 1'b0;
      tick(); tick(); tick();
      chk("ab_bit3", 32'(if0.serial_out), 32'd1);
      if0.abort       = 1'b1;
      if0.load_valid  = 1'b1;
      if0.parallel_in = 8'h00;
      #1;
      chk("ab_ready_blocked", 32'(if0.load_ready), 32'd0);
      tick();
      if0.abort      = 1'b0;
      if0.load_valid = 1'b0;
      chk("ab_serial", 32'(if0.serial_out), 32'd1);
      chk("ab_busy",   32'(if0.busy),       32'd0);
      chk("ab_done",   32'(if0.done),       32'd0);
      tick();
      chk("ab_no_done", 32'(if0.done), 32'd0);
      chk("ab_no_load", 32'(if0.busy), 32'd0);

      // Abort in IDLE blocks a load that cycle
      if0.abort      = 1'b1;
      if0.load_valid = 1'b1;
      #1;
      chk("ab_idle_ready", 32'(if0.load_ready), 32'd0);
      tick();
      if0.abort      = 1'b0;
      if0.load_valid = 1'b0;
      chk("ab_idle_busy", 32'(if0.busy), 32'd0);
      chk("ab_idle_out",  32'(if0.serial_out), 32'd1);

      seq8 = 8'b1000_0001;
      run_word0("w81", 8'h81, seq8);

      // Reset during bit 5
      @(negedge clk);
      if0.load_valid  = 1'b1;
      if0.parallel_in = 8'hA5;
      tick();
      if0.load_valid = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      chk("rmid_bit5", 32'(if0.serial_out), 32'd1);
      chk("rmid_busy_pre", 32'(if0.busy), 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("rmid_serial", 32'(if0.serial_out), 32'd1);
      chk("rmid_busy",   32'(if0.busy),       32'd0);
      chk("rmid_done",   32'(if0.done),       32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      #1;
      chk("rmid_ready", 32'(if0.load_ready), 32'd1);
      tick();
      chk("rmid_no_done", 32'(if0.done), 32'd0);
      seq8 = 8'b0011_1100;
      run_word0("w3c", 8'h3C, seq8);

      // dut1: 0x0D LSB first, 3 cycles per bit, load_valid held mid-word
      seq8 = 8'b1011_0000;
      @(negedge clk);
      if1.load_valid  = 1'b1;
      if1.parallel_in = 8'h0D;
      for (int c = 0; c <= 25; c++) begin
         tick();
         if (c == 0) if1.parallel_in = 8'hFF;
         if (c == 22) if1.load_valid = 1'b0;
         if (c < 24) begin
            chk("p3_bit",   32'(if1.serial_out), 32'(seq8[c / 3]));
            chk("p3_busy",  32'(if1.busy), 32'd1);
            chk("p3_done",  32'(if1.done), 32'd0);
            chk("p3_ready", 32'(if1.load_ready), (c == 23) ? 32'd1 : 32'd0);
         end else if (c == 24) begin
            chk("p3_done_end", 32'(if1.done), 32'd1);
            chk("p3_busy_end", 32'(if1.busy), 32'd0);
            chk("p3_idle_out", 32'(if1.serial_out), 32'd1);
         end else begin
            chk("p3_done_once", 32'(if1.done), 32'd0);
            chk("p3_stay_idle", 32'(if1.busy), 32'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
